// File: rtl/dlx_mem_pkg.sv
// ---------------------------------------------------------------------------
// dlx_mem_pkg
// Definitions shared by the DLX data-side and instruction-side memory
// controllers:
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD; 2'b11 is treated
//     as a word)
//   - controller state encoding (ST_IDLE / ST_REQ / ST_DONE)
//   - big-endian lane helpers: alignment test, byte-enable generation, store
//     replication and load extraction/extension
// ---------------------------------------------------------------------------
package dlx_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Halves must be 2-byte aligned, words (and the reserved size) 4-byte.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] a);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~a[0];
            default: ok = (a == 2'b00);
        endcase
        return ok;
    endfunction

    // Big-endian: byte offset 0 lives in bits 31:24, i.e. lane 3.
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b1000 >> a;
            SZ_HALF: be = a[1] ? 4'b0011 : 4'b1100;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the right-justified store data into every lane so the byte
    // enables alone select the target bytes.
    function automatic logic [31:0] store_steer(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] r;
        case (size)
            SZ_BYTE: r = {4{wd[7:0]}};
            SZ_HALF: r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    // Pull the addressed byte/half out of a bus word and extend it.
    function automatic logic [31:0] load_extend(input logic [1:0]  size,
                                                input logic        sgn,
                                                input logic [1:0]  a,
                                                input logic [31:0] data);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = data[31:24];
            2'd1:    b = data[23:16];
            2'd2:    b = data[15:8];
            default: b = data[7:0];
        endcase
        h = a[1] ? data[15:0] : data[31:16];
        case (size)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default: r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dlx_lane_align.sv
// ---------------------------------------------------------------------------
// dlx_lane_align
// Purely combinational big-endian lane logic for the data-memory controller.
// Ports:
//   size      in  2   access size (dlx_mem_pkg SZ_* encodings)
//   sgn       in  1   sign-extend loads when 1
//   addr_lo   in  2   byte offset within the word
//   we        in  1   1 = store; byte enables are forced to 0 for loads
//   wdata     in  32  right-justified store data
//   rdata     in  32  raw bus read word
//   aligned   out 1   access honours the size alignment rule
//   be        out 4   byte enables (be[3] = bits 31:24)
//   wdata_bus out 32  lane-replicated store data
//   rdata_ext out 32  extracted and extended load data
// ---------------------------------------------------------------------------
module dlx_lane_align
    import dlx_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [1:0]  addr_lo,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        aligned,
    output logic [3:0]  be,
    output logic [31:0] wdata_bus,
    output logic [31:0] rdata_ext
);

    logic [3:0] be_raw;

    assign aligned   = is_aligned(size, addr_lo);
    assign be_raw    = lane_be(size, addr_lo);
    assign wdata_bus = store_steer(size, wdata);
    assign rdata_ext = load_extend(size, sgn, addr_lo, rdata);

    // Reads never assert byte enables.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_be
            assign be[gi] = we & be_raw[gi];
        end
    endgenerate

endmodule

// File: rtl/dlx_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// dlx_dmem_ctrl
// Data-memory controller behind the DLX memory-access stage. Runs each
// load/store on a req/ack bus with wait states, stalls the pipeline until the
// access completes, and aborts on misalignment or bus timeout.
// Optional build macro: DMEM_STORE_BUFFER_EN (one-entry posted-write buffer).
// Ports:
//   clock, reset                      clock and async active-high reset
//   cpu_rd/cpu_wr/cpu_size/cpu_signed request from the pipeline (store wins)
//   cpu_addr, cpu_wdata               byte address, right-justified store data
//   cpu_rdata, cpu_err                result, valid in DONE, held until next DONE
//   cpu_stall                         combinational pipeline freeze
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata  registered bus request
//   bus_rdata, bus_ack                bus response (one-cycle ack strobe)
// ---------------------------------------------------------------------------
module dlx_dmem_ctrl
    import dlx_mem_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_signed,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        cpu_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [31:0]      cpu_rdata_reg;
    logic             cpu_err_reg;
    logic             bus_req_reg;
    logic             bus_we_reg;
    logic [31:0]      bus_addr_reg;
    logic [3:0]       bus_be_reg;
    logic [31:0]      bus_wdata_reg;

    logic             access;
    logic             aligned;
    logic [3:0]       be_lane;
    logic [31:0]      wdata_lane;
    logic [31:0]      rdata_ext;

    assign access = cpu_rd | cpu_wr;

    dlx_lane_align u_align (
        .size      (cpu_size),
        .sgn       (cpu_signed),
        .addr_lo   (cpu_addr[1:0]),
        .we        (cpu_wr),
        .wdata     (cpu_wdata),
        .rdata     (bus_rdata),
        .aligned   (aligned),
        .be        (be_lane),
        .wdata_bus (wdata_lane),
        .rdata_ext (rdata_ext)
    );

`ifdef DMEM_STORE_BUFFER_EN
    logic pend_reg;       // posted write outstanding on the bus
    logic err_pulse_reg;  // clears cpu_err after a one-cycle posted-write error
    logic post_ok;

    // An aligned store with the buffer free is absorbed without stalling.
    assign post_ok   = cpu_wr & aligned & ~pend_reg;
    assign cpu_stall = ((state_reg == ST_IDLE) & access & ~post_ok) | (state_reg == ST_REQ);
`else
    assign cpu_stall = ((state_reg == ST_IDLE) & access) | (state_reg == ST_REQ);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            cpu_rdata_reg <= '0;
            cpu_err_reg   <= 1'b0;
            bus_req_reg   <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_addr_reg  <= '0;
            bus_be_reg    <= '0;
            bus_wdata_reg <= '0;
`ifdef DMEM_STORE_BUFFER_EN
            pend_reg      <= 1'b0;
            err_pulse_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
`ifdef DMEM_STORE_BUFFER_EN
                    if (err_pulse_reg) begin
                        cpu_err_reg   <= 1'b0;
                        err_pulse_reg <= 1'b0;
                    end
                    // Drain the posted write before accepting anything new.
                    if (pend_reg) begin
                        if (bus_ack) begin
                            bus_req_reg <= 1'b0;
                            pend_reg    <= 1'b0;
                        end else if (cnt_reg == CNT_LAST) begin
                            bus_req_reg   <= 1'b0;
                            pend_reg      <= 1'b0;
                            cpu_err_reg   <= 1'b1;
                            err_pulse_reg <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end else
`endif
                    if (access) begin
                        if (aligned) begin
                            bus_addr_reg  <= {cpu_addr[31:2], 2'b00};
                            bus_we_reg    <= cpu_wr;
                            bus_be_reg    <= be_lane;
                            bus_wdata_reg <= wdata_lane;
                            bus_req_reg   <= 1'b1;
                            cnt_reg       <= '0;
`ifdef DMEM_STORE_BUFFER_EN
                            if (post_ok)
                                pend_reg <= 1'b1;
                            else
                                state_reg <= ST_REQ;
`else
                            state_reg     <= ST_REQ;
`endif
                        end else begin
                            // Misaligned: report without touching the bus.
                            cpu_err_reg   <= 1'b1;
                            cpu_rdata_reg <= '0;
                            state_reg     <= ST_DONE;
                        end
                    end
                end

                ST_REQ: begin
                    // Ack takes priority over a simultaneous timeout.
                    if (bus_ack) begin
                        bus_req_reg <= 1'b0;
                        if (!bus_we_reg)
                            cpu_rdata_reg <= rdata_ext;
                        cpu_err_reg <= 1'b0;
                        state_reg   <= ST_DONE;
                    end else if (cnt_reg == CNT_LAST) begin
                        bus_req_reg   <= 1'b0;
                        cpu_err_reg   <= 1'b1;
                        cpu_rdata_reg <= '0;
                        state_reg     <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                // The pipeline advances this cycle; the request still on the
                // inputs belongs to the finished access and is dropped.
                ST_DONE: state_reg <= ST_IDLE;

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign cpu_rdata = cpu_rdata_reg;
    assign cpu_err   = cpu_err_reg;
    assign bus_req   = bus_req_reg;
    assign bus_we    = bus_we_reg;
    assign bus_addr  = bus_addr_reg;
    assign bus_be    = bus_be_reg;
    assign bus_wdata = bus_wdata_reg;

endmodule

// File: tb/tb_dlx_dmem_ctrl.sv
module tb_dlx_dmem_ctrl;

    logic        clk;
    logic        rst;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [1:0]  cpu_size;
    logic        cpu_signed;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int n_cmp = 0;
    int n_bad = 0;

    dlx_dmem_ctrl #(.TIMEOUT(15), .CNT_W(8)) dut (
        .clock      (clk),
        .reset      (rst),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .cpu_size   (cpu_size),
        .cpu_signed (cpu_signed),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .cpu_err    (cpu_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Observations of the most recent access.
    int          o_stall;
    int          o_req;
    logic [31:0] o_addr;
    logic [3:0]  o_be;
    logic        o_we;
    logic [31:0] o_wdata;
    logic [31:0] o_rdata;
    logic        o_err;
    logic        o_done;

    // Called just after a negedge with the controller idle. Drives one
    // request, acks the bus on REQ cycle ack_at (0 = never), and records what
    // the DUT showed up to and including the DONE cycle.
    task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz,
                             input logic sgn, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rdat,
                             input int ack_at);
        cpu_rd = rd; cpu_wr = wr; cpu_size = sz; cpu_signed = sgn;
        cpu_addr = addr; cpu_wdata = wd;
        o_stall = 0; o_req = 0; o_addr = '0; o_be = '0; o_we = 1'b0;
        o_wdata = '0; o_rdata = '0; o_err = 1'b0; o_done = 1'b0;
        #1;
        for (int k = 0; k < 40; k++) begin
            bus_ack = 1'b0;
            if (cpu_stall) o_stall++;
            if (bus_req) begin
                o_req++;
                if (o_req == 1) begin
                    o_addr = bus_addr; o_be = bus_be; o_we = bus_we; o_wdata = bus_wdata;
                end
                if (o_req == ack_at) begin
                    bus_ack = 1'b1;
                    bus_rdata = rdat;
                end
            end
            if (!cpu_stall) begin
                o_rdata = cpu_rdata;
                o_err = cpu_err;
                o_done = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        check_val("done_reached", 32'(o_done), 32'd1);
        cpu_rd = 1'b0; cpu_wr = 1'b0; bus_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int nr;
        rst = 1'b1;
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_size = 2'b00; cpu_signed = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; bus_rdata = '0; bus_ack = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check_val("rst_rdata", cpu_rdata, 32'h0);
        check_val("rst_err", 32'(cpu_err), 32'd0);
        check_val("rst_req", 32'(bus_req), 32'd0);
        check_val("rst_we", 32'(bus_we), 32'd0);
        check_val("rst_addr", bus_addr, 32'h0);
        check_val("rst_be", 32'(bus_be), 32'd0);
        check_val("rst_wdata", bus_wdata, 32'h0);
        check_val("rst_stall", 32'(cpu_stall), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // LW 0x104, ack on 2nd REQ cycle
        do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 2);
        $display("LW 0x104: rdata=%08h err=%0d stall=%0d", o_rdata, o_err, o_stall);
        check_val("lw_addr", o_addr, 32'h0000_0104);
        check_val("lw_be", 32'(o_be), 32'h0);
        check_val("lw_we", 32'(o_we), 32'd0);
        check_val("lw_stall", 32'(o_stall), 32'd3);
        check_val("lw_req", 32'(o_req), 32'd2);
        check_val("lw_rdata", o_rdata, 32'hDEAD_BEEF);
        check_val("lw_err", 32'(o_err), 32'd0);

        // LB signed / unsigned at 0x103 (lane 0)
        do_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 32'h1122_3380, 1);
        $display("LB s 0x103: rdata=%08h err=%0d", o_rdata, o_err);
        check_val("lbs_addr", o_addr, 32'h0000_0100);
        check_val("lbs_stall", 32'(o_stall), 32'd2);
        check_val("lbs_rdata", o_rdata, 32'hFFFF_FF80);
        do_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'h1122_3380, 1);
        $display("LB u 0x103: rdata=%08h err=%0d", o_rdata, o_err);
        check_val("lbu_rdata", o_rdata, 32'h0000_0080);

        // LH signed at 0x100 (upper half)
        do_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0100, 32'h0, 32'h8001_7FFF, 1);
        $display("LH s 0x100: rdata=%08h err=%0d", o_rdata, o_err);
        check_val("lhs_rdata", o_rdata, 32'hFFFF_8001);

        // SH 0x202: lower half lanes; load result register untouched
        do_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 32'h5555_5555, 1);
        $display("SH 0x202: we=%0d be=%b wdata=%08h err=%0d", o_we, o_be, o_wdata, o_err);
        check_val("sh_we", 32'(o_we), 32'd1);
        check_val("sh_be", 32'(o_be), 32'h3);
        check_val("sh_wdata", o_wdata, 32'hABCD_ABCD);
        check_val("sh_addr", o_addr, 32'h0000_0200);
        check_val("sh_err", 32'(o_err), 32'd0);
        check_val("sh_rdata_hold", o_rdata, 32'hFFFF_8001);

        // SB 0x301 with rd also set: store wins, lane 2
        do_access(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0301, 32'h0000_005A, 32'h0, 1);
        $display("SB 0x301: we=%0d be=%b wdata=%08h", o_we, o_be, o_wdata);
        check_val("sb_we", 32'(o_we), 32'd1);
        check_val("sb_be", 32'(o_be), 32'h4);
        check_val("sb_wdata", o_wdata, 32'h5A5A_5A5A);

        // LW misaligned 0x101
        do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 32'h1234_5678, 1);
        $display("LW 0x101: rdata=%08h err=%0d stall=%0d req=%0d", o_rdata, o_err, o_stall, o_req);
        check_val("mis_req", 32'(o_req), 32'd0);
        check_val("mis_stall", 32'(o_stall), 32'd1);
        check_val("mis_err", 32'(o_err), 32'd1);
        check_val("mis_rdata", o_rdata, 32'h0);

        // Read timeout, no ack
        do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 32'h0, 0);
        $display("LW timeout: rdata=%08h err=%0d req=%0d", o_rdata, o_err, o_req);
        check_val("to_req", 32'(o_req), 32'd15);
        check_val("to_stall", 32'(o_stall), 32'd16);
        check_val("to_err", 32'(o_err), 32'd1);
        check_val("to_rdata", o_rdata, 32'h0);

        // Ack in the 15th REQ cycle beats the timeout
        do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 32'hCAFE_0001, 15);
        $display("LW ack@15: rdata=%08h err=%0d req=%0d", o_rdata, o_err, o_req);
        check_val("ack15_req", 32'(o_req), 32'd15);
        check_val("ack15_err", 32'(o_err), 32'd0);
        check_val("ack15_rdata", o_rdata, 32'hCAFE_0001);

        // Reset in the 3rd REQ cycle
        cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_size = 2'b10; cpu_addr = 32'h0000_0500;
        nr = 0;
        for (int k = 0; k < 10 && nr < 3; k++) begin
            @(negedge clk);
            if (bus_req) nr++;
        end
        check_val("rstmid_reached", 32'(nr), 32'd3);
        rst = 1'b1;
        #1;
        $display("reset mid-REQ: bus_req=%0d", bus_req);
        check_val("rstmid_req", 32'(bus_req), 32'd0);
        cpu_rd = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'h9999_9999;
        @(negedge clk);
        bus_ack = 1'b0;
        $display("late ack: req=%0d stall=%0d err=%0d rdata=%08h", bus_req, cpu_stall, cpu_err, cpu_rdata);
        check_val("late_req", 32'(bus_req), 32'd0);
        check_val("late_stall", 32'(cpu_stall), 32'd0);
        check_val("late_err", 32'(cpu_err), 32'd0);
        check_val("late_rdata", cpu_rdata, 32'h0);

        // Controller is back to a clean IDLE: a fresh load behaves normally
        do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0, 32'h0BAD_F00D, 1);
        $display("LW after reset: rdata=%08h err=%0d stall=%0d", o_rdata, o_err, o_stall);
        check_val("post_stall", 32'(o_stall), 32'd2);
        check_val("post_rdata", o_rdata, 32'h0BAD_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dlx_dmem_ctrl.md
Name: dlx_dmem_ctrl

Overview:
Data-memory controller directly downstream of the DLX pipeline's memory-access stage. Takes the stage's load/store request (address, store data, size) and runs it on a req/ack external data bus with wait states. Performs big-endian byte-lane steering and load sign/zero extension. Stalls the pipeline until each access completes, aborts on misalignment or bus timeout, and returns the load result to the write-back path.

Parameters:
TIMEOUT, 15, cycles in REQ without bus_ack before abort (1..255)
CNT_W, 8, width of the timeout counter

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
cpu_rd  in  1  load request; held stable while cpu_stall=1
cpu_wr  in  1  store request; held stable while cpu_stall=1
cpu_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
cpu_signed  in  1  loads: 1 sign-extend, 0 zero-extend
cpu_addr  in  32  byte address (ALU result)
cpu_wdata  in  32  store data, right-justified
cpu_rdata  out  32  extended load data; valid in DONE
cpu_stall  out  1  freeze pipeline
cpu_err  out  1  access aborted (misaligned or timeout); valid in DONE
bus_req  out  1  bus request
bus_we  out  1  1 write, 0 read
bus_addr  out  32  word address, {cpu_addr[31:2],2'b00}
bus_be  out  4  byte enables; be[3]=bits 31:24
bus_wdata  out  32  lane-steered store data
bus_rdata  in  32  read data; sampled on bus_ack
bus_ack  in  1  one-cycle completion strobe

Behaviour:
- Reset (async): state=IDLE; counter=0; all outputs 0 (cpu_rdata, cpu_err, bus_req, bus_we, bus_addr, bus_be, bus_wdata). Reset mid-access drops bus_req at once; any late bus_ack is ignored.
- access = cpu_rd|cpu_wr. If both are set, the access is a store.
- cpu_stall = (IDLE & access) | REQ. It is combinational and low in DONE.
- Alignment rules: half needs addr[0]=0; word needs addr[1:0]=00.
- IDLE, access, aligned: register bus_addr, bus_we, bus_be and bus_wdata; set bus_req=1; go to REQ; counter=0.
- IDLE, access, misaligned: go to DONE with err=1 and rdata=0. The bus is not touched.
- REQ, bus_ack=1: drop bus_req. For loads, capture the extracted and extended bus_rdata. Set err=0. Go to DONE.
- REQ, no ack: counter++. When counter reaches TIMEOUT-1 without ack, drop bus_req, set err=1 and rdata=0, and go to DONE.
- Ack and timeout in the same cycle: ack wins.
- DONE: lasts exactly one cycle. cpu_rdata and cpu_err are valid and the stall is low, so the pipeline advances. Always goes to IDLE; the still-present request is not re-accepted.
- cpu_rdata and cpu_err hold their value until the next DONE.
- Byte lanes are big-endian:
  - Byte at addr[1:0]=k uses lane 3-k.
  - Half at addr[1]=0 uses be=1100; at addr[1]=1 uses be=0011.
  - Word uses be=1111.
- Store data is replicated into the selected lane; bus_be=0000 for reads.
- Minimum latency: 3 cycles from request to DONE (IDLE, REQ with ack in the first REQ cycle, DONE).

Optional Feature:
DMEM_STORE_BUFFER_EN
- Compiled in: one-entry posted-write buffer.
  - An aligned store in IDLE with the buffer empty is captured without stall (cpu_stall=0 that cycle). The buffer then issues the bus write on its own.
  - A load or store arriving while the buffer is pending stalls until the write is acked or times out, then proceeds normally.
  - A timeout on a posted write pulses cpu_err for one cycle, with no DONE state.
- Compiled out: stores follow the IDLE/REQ/DONE flow like loads.

Decomposition:
- Shared package dlx_mem_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - state enum ST_IDLE, ST_REQ, ST_DONE
  - lane-steering and extension functions, which the instruction-side controller reuses
- Sub-module dlx_lane_align: combinational store-steering/be generation plus load extraction/extension. The FSM and counter stay in the top module.

Test Plan:
- LW addr 0x0000_0104, bus_rdata 0xDEAD_BEEF, ack on 2nd REQ cycle -> bus_addr 0x104, be=0000, bus_we=0; stall 3 cycles; cpu_rdata=0xDEAD_BEEF, err=0.
- LB signed addr 0x103, bus_rdata 0x1122_3380 -> cpu_rdata=0xFFFF_FF80. Same access unsigned -> 0x0000_0080.
- SH addr 0x202, wdata 0x0000_ABCD -> bus_we=1, be=0011, bus_wdata low half 0xABCD; err=0.
- LW addr 0x101 -> no bus_req ever; 1 stall cycle; DONE with err=1, rdata=0.
- Read with no ack, TIMEOUT=15 -> bus_req high exactly 15 cycles, then DONE with err=1. Variant: ack in the 15th cycle -> err=0.
- Reset asserted in the 3rd REQ cycle -> bus_req=0 immediately. Ack one cycle after reset release -> ignored, state IDLE. With DMEM_STORE_BUFFER_EN: SW then LW back-to-back -> SW has no stall; LW stalls until the write ack.
